// File: rtl/seq_generator.sv
// Serial pattern generator: shifts a captured pattern out MSB first, repeated a
// programmable number of times with an optional idle gap between repetitions.
module seq_generator #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   latch_q, latch_d;
  logic [BW-1:0]      bitCnt_q, bitCnt_d;
  logic [REP_W-1:0]   repCnt_q, repCnt_d;
  logic [GW-1:0]      gapCnt_q, gapCnt_d;
  logic               dout_q, dout_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      latch_q  <= '0;
      bitCnt_q <= '0;
      repCnt_q <= '0;
      gapCnt_q <= '0;
      dout_q   <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      latch_q  <= latch_d;
      bitCnt_q <= bitCnt_d;
      repCnt_q <= repCnt_d;
      gapCnt_q <= gapCnt_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // repCnt_q holds the repetitions still owed, including the one being sent.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    latch_d  = latch_q;
    bitCnt_d = bitCnt_q;
    repCnt_d = repCnt_q;
    gapCnt_d = gapCnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_SEND;
          shift_d  = pattern;
          latch_d  = pattern;
          bitCnt_d = '0;
          repCnt_d = (reps == '0) ? REP_W'(1) : reps;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          if (repCnt_q > REP_W'(1)) begin
            repCnt_d = repCnt_q - REP_W'(1);
            if (GAP > 0) begin
              state_d  = S_GAP;
              gapCnt_d = '0;
            end else begin
              shift_d = latch_q;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          shift_d  = {shift_q[WIDTH-2:0], 1'b0};
          bitCnt_d = bitCnt_q + BW'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gapCnt_q == GAP_LAST) begin
          state_d = S_SEND;
          shift_d = latch_q;
        end else begin
          gapCnt_d = gapCnt_q + GW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    dout_d = (state_d == S_SEND) ? shift_d[WIDTH-1] : 1'b0;
    vld_d  = (state_d == S_SEND);
    busy_d = (state_d == S_SEND) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: one instance with GAP=2 and one with GAP=0,
// checked at falling edges against hand-derived output vectors.
module tb_seq_generator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start0;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] reps;
  logic       dout, dout_vld, busy, done;
  logic       dout0, dout_vld0, busy0, done0;

  int vectors;
  int miscompares;

  seq_generator #(.WIDTH(8), .GAP(2), .REP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern(pattern), .reps(reps),
    .dout(dout), .dout_vld(dout_vld), .busy(busy), .done(done)
  );

  seq_generator #(.WIDTH(8), .GAP(0), .REP_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .pattern(pattern), .reps(reps),
    .dout(dout0), .dout_vld(dout_vld0), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after a falling edge; the start pulse spans one rising edge.
  task automatic applyStimulus(input logic [7:0] pat, input logic [3:0] n);
    pattern = pat;
    reps    = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Walks a full transmission cycle by cycle, optionally poking start/pattern mid-SEND.
  task automatic expectStream(input string tag, input logic [7:0] pat, input int nreps,
                              input int gap, input int pokeAt, input int expBusy, input int expVld);
    int cyc = 0;
    int busyN = 0;
    int vldN = 0;
    for (int r = 0; r < nreps; r++) begin
      for (int b = 0; b < 8; b++) begin
        if (cyc == pokeAt) begin
          start = 1'b1;
          pattern = 8'h00;
          reps = 4'd5;
        end else if (cyc == pokeAt + 1) begin
          start = 1'b0;
        end
        checkOutput({tag, " send"}, {28'd0, dout, dout_vld, busy, done}, {28'd0, pat[7-b], 3'b110});
        busyN += int'(busy);
        vldN += int'(dout_vld);
        @(negedge clk);
        cyc++;
      end
      if (r < nreps - 1) begin
        for (int g = 0; g < gap; g++) begin
          checkOutput({tag, " gap"}, {28'd0, dout, dout_vld, busy, done}, 32'b0010);
          busyN += int'(busy);
          vldN += int'(dout_vld);
          @(negedge clk);
          cyc++;
        end
      end
    end
    checkOutput({tag, " done"}, {28'd0, dout, dout_vld, busy, done}, 32'b0001);
    @(negedge clk);
    checkOutput({tag, " idle"}, {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    checkOutput({tag, " busyCycles"}, busyN, expBusy);
    checkOutput({tag, " vldCycles"}, vldN, expVld);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    start = 1'b0;
    start0 = 1'b0;
    abort = 1'b0;
    pattern = 8'h00;
    reps = 4'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    checkOutput("reset0", {28'd0, dout0, dout_vld0, busy0, done0}, 32'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postReset", {28'd0, dout, dout_vld, busy, done}, 32'b0000);

    applyStimulus(8'hB5, 4'd1);
    expectStream("single", 8'hB5, 1, 2, -1, 8, 8);

    // Start lands in the first IDLE cycle after DONE.
    applyStimulus(8'hB5, 4'd3);
    expectStream("triple", 8'hB5, 3, 2, -1, 28, 24);

    applyStimulus(8'hB5, 4'd0);
    expectStream("repsZero", 8'hB5, 1, 2, -1, 8, 8);

    pattern = 8'hB5;
    reps = 4'd2;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("gap0 send", {28'd0, dout0, dout_vld0, busy0, done0}, {28'd0, pattern[7-(i%8)], 3'b110});
      @(negedge clk);
    end
    checkOutput("gap0 done", {28'd0, dout0, dout_vld0, busy0, done0}, 32'b0001);
    @(negedge clk);
    checkOutput("gap0 idle", {28'd0, dout0, dout_vld0, busy0, done0}, 32'b0000);

    applyStimulus(8'hB5, 4'd1);
    expectStream("startInSend", 8'hB5, 1, 2, 3, 8, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("noQueue", {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    end

    applyStimulus(8'hB5, 4'd3);
    for (int b = 0; b < 4; b++) begin
      checkOutput("preAbort", {28'd0, dout, dout_vld, busy, done}, {28'd0, pattern[7-b], 3'b110});
      @(negedge clk);
    end
    checkOutput("abortBit4", {28'd0, dout, dout_vld, busy, done}, {28'd0, pattern[3], 3'b110});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("aborted", {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    @(negedge clk);
    checkOutput("abortNoDone", {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    applyStimulus(8'hB5, 4'd1);
    expectStream("afterAbort", 8'hB5, 1, 2, -1, 8, 8);

    abort = 1'b1;
    applyStimulus(8'hB5, 4'd1);
    abort = 1'b0;
    checkOutput("abortWins", {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    @(negedge clk);
    checkOutput("abortWins2", {28'd0, dout, dout_vld, busy, done}, 32'b0000);

    applyStimulus(8'hB5, 4'd2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("preReset", {28'd0, dout, dout_vld, busy, done}, {28'd0, pattern[5], 3'b110});
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncReset", {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    @(negedge clk);
    checkOutput("heldReset", {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("releasedIdle", {28'd0, dout, dout_vld, busy, done}, 32'b0000);
    applyStimulus(8'h6C, 4'd1);
    expectStream("afterReset", 8'h6C, 1, 2, -1, 8, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
